// File: rtl/secded_mem_engine.sv
// SECDED Hamming(16,11) engine that walks the data memory: encodes 11-bit messages
// into 16-bit codewords, or decodes codewords with single-error correction and double-error flagging.
module secded_mem_engine #(
    parameter int unsigned WORDS    = 15,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned CNT_W    = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              mode,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [CNT_W-1:0]  single_cnt,
    output logic [CNT_W-1:0]  double_cnt
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic [ADDR_W-2:0] idx;
    logic [7:0]        lo_q;
    logic [7:0]        res_hi_q;

    logic [ADDR_W-1:0] off, off_next, src_addr, dst_addr, src_next;
    logic [15:0]       cw, enc_cw, fixed, res;
    logic [10:0]       dout;
    logic [3:0]        syn;
    logic              par, is_single, is_double, last;

    assign off      = {idx, 1'b0};
    assign off_next = off + ADDR_W'(2);
    assign src_addr = ADDR_W'(SRC_BASE) + off;
    assign dst_addr = ADDR_W'(DST_BASE) + off;
    assign src_next = ADDR_W'(SRC_BASE) + off_next;
    assign last     = (idx == (ADDR_W-1)'(WORDS - 1));

    // Result is formed during CAP straight from the high byte on the read bus, so it
    // can be registered at the CAP->WR_LO edge and both write bytes come from flops.
    always_comb begin
        cw = '0;
        if (mode_q) begin
            cw = {mem_rd_data, lo_q};
        end else begin
            cw[15:9] = {mem_rd_data[2:0], lo_q[7:4]};
            cw[7:5]  = lo_q[3:1];
            cw[3]    = lo_q[0];
        end
        syn = '0;
        for (int unsigned k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        par = ^cw;

        enc_cw    = cw;
        enc_cw[1] = syn[0];
        enc_cw[2] = syn[1];
        enc_cw[4] = syn[2];
        enc_cw[8] = syn[3];
        enc_cw[0] = ^enc_cw[15:1];

        fixed = cw;
        if (syn != '0 && par) fixed[syn] = ~fixed[syn];
        is_single = par;
        is_double = (syn != '0) && !par;
        dout      = {fixed[15:9], fixed[7:5], fixed[3]};

        res = mode_q ? {is_double, 4'b0, dout[10:8], dout[7:0]} : enc_cw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ack         <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            single_cnt  <= '0;
            double_cnt  <= '0;
            idx         <= '0;
            mode_q      <= 1'b0;
            lo_q        <= '0;
            res_hi_q    <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        mode_q     <= mode;
                        single_cnt <= '0;
                        double_cnt <= '0;
                        idx        <= '0;
                        ack        <= 1'b0;
                        mem_addr   <= ADDR_W'(SRC_BASE);
                        state      <= RD_LO;
                    end
                end
                RD_LO: begin
                    mem_addr <= src_addr + ADDR_W'(1);
                    state    <= RD_HI;
                end
                RD_HI: begin
                    lo_q  <= mem_rd_data;
                    state <= CAP;
                end
                CAP: begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= dst_addr;
                    mem_wr_data <= res[7:0];
                    res_hi_q    <= res[15:8];
                    if (mode_q && is_single && single_cnt != '1) single_cnt <= single_cnt + 1'b1;
                    if (mode_q && is_double && double_cnt != '1) double_cnt <= double_cnt + 1'b1;
                    state <= WR_LO;
                end
                WR_LO: begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= dst_addr + ADDR_W'(1);
                    mem_wr_data <= res_hi_q;
                    state       <= WR_HI;
                end
                WR_HI: begin
                    if (last) begin
                        ack   <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx      <= idx + 1'b1;
                        mem_addr <= src_next;
                        state    <= RD_LO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secded_mem_engine.sv
// Scoreboard bench for secded_mem_engine: a byte memory model, expected writes queued
// at run start, and a monitor that pops and compares on every write strobe.
module tb_secded_mem_engine;

    localparam int unsigned W   = 3;
    localparam int unsigned AW  = 8;
    localparam int unsigned SRC = 0;
    localparam int unsigned DST = 30;
    localparam int unsigned CW  = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          mode = 1'b0;
    logic          ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [CW-1:0] single_cnt;
    logic [CW-1:0] double_cnt;

    logic [7:0] mem [256];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_seen = 0;

    secded_mem_engine #(
        .WORDS(W),
        .ADDR_W(AW),
        .SRC_BASE(SRC),
        .DST_BASE(DST),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .mode(mode),
        .ack(ack),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .single_cnt(single_cnt),
        .double_cnt(double_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next queued expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset && mem_wr_en) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(mem_addr), int'(e.addr));
                    check("wr_data", int'(mem_wr_data), int'(e.data));
                end
            end
        end
    end

    task automatic load_word(input int i, input logic [7:0] lo, input logic [7:0] hi);
        mem[SRC + 2*i]     <= lo;
        mem[SRC + 2*i + 1] <= hi;
    endtask

    task automatic push_exp(input int i, input logic [7:0] lo, input logic [7:0] hi);
        wr_t e;
        e.addr = 8'(DST + 2*i);
        e.data = lo;
        exp_q.push_back(e);
        e.addr = 8'(DST + 2*i + 1);
        e.data = hi;
        exp_q.push_back(e);
    endtask

    // Issue req, then wait for ack; optionally pulse req again at cycle mid of the run.
    task automatic run(input string name, input logic m, input int mid,
                       input int exp_single, input int exp_double);
        int n;
        int base;
        bit got;
        base = wr_seen;
        @(posedge clk); #1;
        req  = 1'b1;
        mode = m;
        @(posedge clk); #1;
        req = 1'b0;
        check({name, "_ack_drop"}, int'(ack), 0);
        check({name, "_cnt_clear"}, int'(single_cnt) + int'(double_cnt), 0);
        n = 0;
        got = 0;
        while (n < 200 && !got) begin
            @(posedge clk); #1;
            n++;
            req = (n == mid);
            if (ack) got = 1;
        end
        req = 1'b0;
        check({name, "_ack_latency"}, n, 5 * W);
        check({name, "_write_count"}, wr_seen - base, 2 * W);
        check({name, "_single_cnt"}, int'(single_cnt), exp_single);
        check({name, "_double_cnt"}, int'(double_cnt), exp_double);
    endtask

    initial begin
        int n;
        int base;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", int'(ack), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wr_data", int'(mem_wr_data), 0);
        check("rst_single", int'(single_cnt), 0);
        check("rst_double", int'(double_cnt), 0);
        reset = 1'b0;

        // ENCODE: 0x000 -> 0x0000, 0x7FF -> 0xFFFF, 0x001 -> 0x000F
        load_word(0, 8'h00, 8'h00);
        load_word(1, 8'hFF, 8'h07);
        load_word(2, 8'h01, 8'h00);
        push_exp(0, 8'h00, 8'h00);
        push_exp(1, 8'hFF, 8'hFF);
        push_exp(2, 8'h0F, 8'h00);
        run("enc", 1'b0, 0, 0, 0);

        // DECODE: data bit flip at pos 5, p16 flip, clean zero
        load_word(0, 8'hDF, 8'hFF);
        load_word(1, 8'hFE, 8'hFF);
        load_word(2, 8'h00, 8'h00);
        push_exp(0, 8'hFF, 8'h07);
        push_exp(1, 8'hFF, 8'h07);
        push_exp(2, 8'h00, 8'h00);
        run("dec_single", 1'b1, 0, 2, 0);

        // Back-to-back from DONE, with a stray req mid-run: double error at 5,9; clean words
        load_word(0, 8'hDF, 8'hFD);
        load_word(1, 8'hFF, 8'hFF);
        load_word(2, 8'h0F, 8'h00);
        push_exp(0, 8'hED, 8'h87);
        push_exp(1, 8'hFF, 8'h07);
        push_exp(2, 8'h01, 8'h00);
        run("dec_double", 1'b1, 7, 0, 1);

        // Reset during WR_LO of the second word
        load_word(0, 8'h00, 8'h00);
        load_word(1, 8'hFF, 8'h07);
        load_word(2, 8'h01, 8'h00);
        push_exp(0, 8'h00, 8'h00);
        push_exp(1, 8'hFF, 8'hFF);
        push_exp(2, 8'h0F, 8'h00);
        base = wr_seen;
        @(posedge clk); #1;
        req  = 1'b1;
        mode = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (wr_seen != base + 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("midrst_reach_wr_lo", wr_seen - base, 3);
        reset = 1'b1;
        #1;
        check("midrst_wr_en", int'(mem_wr_en), 0);
        check("midrst_ack", int'(ack), 0);
        check("midrst_addr", int'(mem_addr), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp(0, 8'h00, 8'h00);
        push_exp(1, 8'hFF, 8'hFF);
        push_exp(2, 8'h0F, 8'h00);
        run("after_rst", 1'b0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_mem_engine.md
Name: secded_mem_engine

Overview:
Memory-walking SECDED Hamming(16,11) engine that sits beside the data memory and is started by the top-level req/ack handshake. In ENCODE mode it reads 11-bit messages from a source region and writes 16-bit codewords to a destination region. In DECODE mode it reads possibly corrupted codewords, corrects single-bit errors, flags double-bit errors, and writes recovered messages. Word count and region bases are parametrised, and per-run single/double error counts are exposed for status.

Parameters:
WORDS, 15, number of 2-byte words processed per run; legal range 1..2^(ADDR_W-1)
ADDR_W, 8, data memory byte-address width
SRC_BASE, 0, byte address of the first source word (low byte; high byte at +1)
DST_BASE, 30, byte address of the first destination word
CNT_W, $clog2(WORDS+1), width of the error counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  start pulse; sampled only in IDLE or DONE
mode  in  1  0 = ENCODE, 1 = DECODE; captured on the cycle req is accepted
ack  out  1  run complete; high in DONE until the next accepted req
mem_addr  out  ADDR_W  byte address to data memory
mem_rd_data  in  8  read data; synchronous memory, valid the cycle after mem_addr
mem_wr_en  out  1  write strobe, one cycle per byte
mem_wr_data  out  8  write data
single_cnt  out  CNT_W  words corrected this run (DECODE only)
double_cnt  out  CNT_W  words flagged double-error this run (DECODE only)

Behaviour:
- Reset (asynchronous): state IDLE, ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counters=0, word index=0, mode register=0.
- Codeword layout: cw[k] is Hamming position k for k=1..15; cw[0] is overall parity p16.
  - cw[15:9]=d[11:5], cw[8]=p8, cw[7:5]=d[4:2], cw[4]=p4, cw[3]=d[1], cw[2]=p2, cw[1]=p1, cw[0]=p16.
  - p16 makes ^cw = 0.
- Message word layout: low byte = d[8:1], high byte = {5'b0, d[11:9]}.
- FSM states: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE.
- IDLE/DONE: on req=1, latch mode, clear counters and index i, drop ack, go to RD_LO. Other inputs are ignored.
- RD_LO: mem_addr = SRC_BASE+2i.
- RD_HI: mem_addr = SRC_BASE+2i+1; capture the low byte.
- CAP: capture the high byte; compute the result combinationally from the captured bytes.
- WR_LO: mem_wr_en=1, mem_addr = DST_BASE+2i, result low byte.
- WR_HI: mem_wr_en=1, mem_addr = DST_BASE+2i+1, result high byte.
  - If i = WORDS-1, go to DONE.
  - Otherwise increment i and go to RD_LO.
- Timing: exactly 5 cycles per word. ack rises on the edge 5*WORDS cycles after req is sampled.
- ENCODE: high-byte bits [7:3] of the source word are ignored.
- DECODE: compute syndrome s = XOR of k over all k in 1..15 where cw[k]=1, and P = ^cw[15:0].
  - s=0, P=0: clean; output the data unchanged.
  - s!=0, P=1: single error; flip cw[s], then extract data; single_cnt+1.
  - s=0, P=1: error in p16 only; data unchanged; single_cnt+1.
  - s!=0, P=0: double error; extract data uncorrected; set output high-byte bit7=1; double_cnt+1.
  - Otherwise output bits [7:3] of the high byte are 0.
- Counters: saturate at 2^CNT_W-1. They hold their value in DONE and clear only on the next accepted req.
- ENCODE leaves both counters at 0.
- req while in RD_LO..WR_HI is ignored and does not restart the run.
- Reset mid-run: immediate return to IDLE; a partially written word is not completed.
- Source and destination regions that overlap are not supported. Behaviour is then undefined, but the FSM must still terminate.
- mem_wr_en is never high outside WR_LO/WR_HI.

Test Plan:
- ENCODE, WORDS=3, source bytes {00,00},{FF,07},{01,00} (lo,hi) -> destination gets {00,00},{FF,FF},{0F,00}. ack rises 15 cycles after req; counters stay 0.
- DECODE codeword 0xFFDF (bit 5 flipped) -> output {FF,07}; single_cnt=1, double_cnt=0.
- DECODE 0xFFFE (p16 flipped) -> output {FF,07}, single_cnt=1. DECODE 0x0000 -> {00,00}, no count.
- DECODE 0xFDDF (bits 5 and 9 flipped) -> high byte bit7=1, i.e. output high byte 0x87; double_cnt=1.
- Back-to-back runs: req pulsed while ack=1 -> ack falls on the next edge and counters clear. A second req mid-run -> ignored; total write count stays exactly 2*WORDS.
- Assert reset during WR_LO of word 2 -> mem_wr_en drops immediately, state IDLE, ack=0. A fresh req then completes normally.
